// File: rtl/bcd_serial_adder_ctrl_if.sv
// Purpose: bundles the request and result signals of the serial packed-BCD adder.
// Latency: none; this is wiring only.
// Backpressure: none; start is only accepted while the sequencer is idle.
// Ports:
//   master drives start/a/b/cin and observes busy/done/s/cout/err.
//   slave is the sequencer side of the same signals.
interface bcd_serial_adder_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   s;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Purpose: adds two packed-BCD operands one digit per clock, LSB digit first.
// Latency: start at edge k -> busy for DIGITS cycles -> done pulse DIGITS+1 cycles later.
// Backpressure: start is ignored outside IDLE; requests are dropped, never queued.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       slave side of bcd_serial_adder_ctrl_if (start/a/b/cin in,
//             busy/done/s/cout/err out)
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_serial_adder_ctrl_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            err_acc_q, err_acc_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  // single-digit BCD add stage
  logic [3:0]      ad, bd, dig;
  logic [4:0]      raw;
  logic            dig_carry;
  logic            dig_err;
  logic [W-1:0]    res_shift;

  always_comb begin
    ad  = a_sh_q[3:0];
    bd  = b_sh_q[3:0];
    raw = {1'b0, ad} + {1'b0, bd} + {4'b0000, carry_q};
    // the +6 correction skips the six unused nibble codes; invalid digits
    // go through the same rule, so no saturation is applied
    if (raw > 5'd9) begin
      dig       = raw[3:0] + 4'd6;
      dig_carry = 1'b1;
    end else begin
      dig       = raw[3:0];
      dig_carry = 1'b0;
    end
    dig_err = (ad > 4'd9) | (bd > 4'd9);

    // new digit enters at the top, so after DIGITS steps digit 0 sits at the LSB
    res_shift            = res_q >> 4;
    res_shift[W-1 -: 4]  = dig;
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    err_acc_d = err_acc_q;
    cout_d    = cout_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d    = bus.a;
          b_sh_d    = bus.b;
          carry_d   = bus.cin;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          res_d     = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        a_sh_d    = a_sh_q >> 4;
        b_sh_d    = b_sh_q >> 4;
        res_d     = res_shift;
        carry_d   = dig_carry;
        err_acc_d = err_acc_q | dig_err;
        if (cnt_q == CW'(DIGITS - 1)) begin
          // outputs are loaded on the last digit so they are valid with done
          s_d     = res_shift;
          cout_d  = dig_carry;
          err_d   = err_acc_q | dig_err;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_q     <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      err_acc_q <= 1'b0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_q     <= res_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      err_acc_q <= err_acc_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy = (state_q == ADD);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Purpose: randomized and directed scoreboard bench for bcd_serial_adder_ctrl.
// Latency: expects done DIGITS cycles after the accepting edge's following cycle.
// Backpressure: stimulus only issues start when the model says the block is idle.
module tb_bcd_serial_adder_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         err;
    int           st;   // edge at which start is accepted
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  logic [W-1:0] last_s = '0;
  logic         last_cout = 1'b0;
  logic         last_err = 1'b0;

  bcd_serial_adder_ctrl_if #(.DIGITS(D)) bus_if ();

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: decimal integer arithmetic for valid operands; for operands
  // with illegal nibbles, the documented per-digit rule applied in sequence.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int st);
    exp_t r;
    bit   valid = 1'b1;
    int   va = 0, vb = 0, sum, pw = 1, c, x;
    for (int i = 0; i < D; i++) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) valid = 1'b0;
    end
    r.st  = st;
    r.err = !valid;
    r.s   = '0;
    if (valid) begin
      for (int i = D - 1; i >= 0; i--) begin
        va = va * 10 + int'(a[4*i +: 4]);
        vb = vb * 10 + int'(b[4*i +: 4]);
        pw = pw * 10;
      end
      sum    = va + vb + int'(cin);
      r.cout = (sum >= pw);
      sum    = sum % pw;
      for (int i = 0; i < D; i++) begin
        r.s[4*i +: 4] = 4'(sum % 10);
        sum = sum / 10;
      end
    end else begin
      c = int'(cin);
      for (int i = 0; i < D; i++) begin
        x = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
        if (x > 9) begin
          r.s[4*i +: 4] = 4'((x + 6) % 16);
          c = 1;
        end else begin
          r.s[4*i +: 4] = 4'(x);
          c = 0;
        end
      end
      r.cout = (c != 0);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) begin
      if (allow_bad && $urandom_range(0, 3) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // called at posedge+#1; leaves the bench at posedge+#1 with the block idle
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int gap);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
    sbq.push_back(model(a, b, cin, cyc + 1));
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
    bus_if.cin   = 1'($urandom);
    repeat (D + 1 + gap) begin @(posedge clk); #1; end
  endtask

  // Monitor: checks busy against the model's schedule, pops on done,
  // and checks that results are held between operations.
  always @(negedge clk) begin
    bit exp_busy;
    exp_t e;
    if (rst) begin
      last_s    = '0;
      last_cout = 1'b0;
      last_err  = 1'b0;
    end else begin
      exp_busy = 1'b0;
      foreach (sbq[i]) if (sbq[i].st <= cyc && cyc <= sbq[i].st + D - 1) exp_busy = 1'b1;
      chk("busy", 32'(bus_if.busy), 32'(exp_busy));
      if (bus_if.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(bus_if.done), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.st + D));
          chk("s", 32'(bus_if.s), 32'(e.s));
          chk("cout", 32'(bus_if.cout), 32'(e.cout));
          chk("err", 32'(bus_if.err), 32'(e.err));
          last_s    = e.s;
          last_cout = e.cout;
          last_err  = e.err;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].st + D == cyc) begin
          chk("missing_done", 32'(bus_if.done), 32'd1);
          void'(sbq.pop_front());
        end
        chk("s_hold", 32'(bus_if.s), 32'(last_s));
        chk("cout_hold", 32'(bus_if.cout), 32'(last_cout));
        chk("err_hold", 32'(bus_if.err), 32'(last_err));
      end
    end
  end

  initial begin
    int wait_cnt;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_op(16'h1234, 16'h5678, 1'b0, 0);
    do_op(16'h9999, 16'h0001, 1'b0, 1);
    do_op(16'h9999, 16'h9999, 1'b1, 0);
    do_op(16'h0999, 16'h0000, 1'b1, 2);
    do_op(16'h0000, 16'h0000, 1'b0, 0);
    do_op(16'h00A0, 16'h0009, 1'b0, 0);
    do_op(16'h4321, 16'h1111, 1'b0, 1);

    // start held high: accepted only from IDLE, operand changes while busy ignored
    begin
      int c0;
      c0 = cyc;
      bus_if.start = 1'b1;
      bus_if.a     = 16'h0001;
      bus_if.b     = 16'h0001;
      bus_if.cin   = 1'b0;
      for (int k = 0; k < 3; k++) sbq.push_back(model(16'h0001, 16'h0001, 1'b0, c0 + 1 + k * (D + 2)));
      for (int j = 1; j <= 13; j++) begin
        @(posedge clk); #1;
        if (j == 2 || j == 8) begin
          bus_if.a = 16'h9999;
          bus_if.b = 16'h9999;
        end
        if (j == 5 || j == 11) begin
          bus_if.a = 16'h0001;
          bus_if.b = 16'h0001;
        end
        if (j == 13) bus_if.start = 1'b0;
      end
      repeat (D + 1) begin @(posedge clk); #1; end
    end

    // reset in the second ADD cycle abandons the operation
    bus_if.start = 1'b1;
    bus_if.a     = 16'h5555;
    bus_if.b     = 16'h4444;
    bus_if.cin   = 1'b1;
    sbq.push_back(model(16'h5555, 16'h4444, 1'b1, cyc + 1));
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(16'h2468, 16'h1357, 1'b0, 0);

    // randomized operations, some with illegal digits
    for (int n = 0; n < 40; n++) begin
      do_op(rand_bcd(n % 3 == 0), rand_bcd(n % 5 == 0), 1'($urandom), int'($urandom_range(0, 2)));
    end

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 30) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
